// File: rtl/ltc2600_pkg.sv
// Shared types for the multi-chip LTC2600 writer: command encodings, queued command record
// and engine states.
package ltc2600_pkg;

    localparam int unsigned FRAME_BITS = 32;
    localparam int unsigned DEV_BITS   = 3;
    localparam int unsigned CODE_BITS  = 16;

    typedef enum logic [3:0] {
        WRITE_N          = 4'h0,
        UPDATE_N         = 4'h1,
        WRITE_UPDATE_ALL = 4'h2,
        WRITE_UPDATE_N   = 4'h3,
        POWER_DOWN_N     = 4'h4,
        NOP              = 4'hF
    } ltc2600_cmd_e;

    // data is stored already left-justified to 16 bits
    typedef struct packed {
        logic                 broadcast;
        logic [DEV_BITS-1:0]  dev;
        logic [3:0]           cmd;
        logic [3:0]           addr;
        logic [CODE_BITS-1:0] data;
    } dac_cmd_t;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StSetup,
        StSckHi,
        StSckLo,
        StHold,
        StGap
    } state_e;

    function automatic logic [FRAME_BITS-1:0] build_frame(dac_cmd_t c);
        return {8'h00, c.cmd, c.addr, c.data};
    endfunction

endpackage

// File: rtl/ltc2600_multi_writer_if.sv
// Command stream into the writer: valid/ready handshake plus the command fields.
interface ltc2600_multi_writer_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEV_W      = 1
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DEV_W-1:0]      s_dev;
    logic                  s_broadcast;
    logic [3:0]            s_cmd;
    logic [3:0]            s_addr;
    logic [DATA_WIDTH-1:0] s_data;

    modport master (
        output s_valid, s_dev, s_broadcast, s_cmd, s_addr, s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid, s_dev, s_broadcast, s_cmd, s_addr, s_data,
        output s_ready
    );
endinterface

// File: rtl/ltc2600_cmd_fifo.sv
// Synchronous command FIFO with occupancy output; pointers carry one wrap bit.
module ltc2600_cmd_fifo
    import ltc2600_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  dac_cmd_t               wdata,
    output logic                   full,
    input  logic                   pop,
    output dac_cmd_t               rdata,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int unsigned AW = $clog2(DEPTH);

    dac_cmd_t      mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/ltc2600_multi_writer.sv
// Queued LTC2600 writer: serialises 32-bit frames to one of N_DEV chips (or all in turn),
// captures the SDO echo and sequences CLRB.
module ltc2600_multi_writer
    import ltc2600_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned N_DEV      = 2,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned SCK_DIV    = 2,
    parameter int unsigned CS_HOLD    = 2,
    parameter int unsigned CS_GAP     = 4,
    parameter int unsigned CLR_CYCLES = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    ltc2600_multi_writer_if.slave       s,
    input  logic                        clear_req,
    input  logic [N_DEV-1:0]            sdo,
    output logic                        sck,
    output logic                        sdi,
    output logic [N_DEV-1:0]            csb,
    output logic                        clrb,
    output logic                        busy,
    output logic                        done,
    output logic [31:0]                 echo_data,
    output logic                        bad_dev,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam logic [15:0] DivLast  = 16'(SCK_DIV - 1);
    localparam logic [15:0] HoldLast = 16'(CS_HOLD - 1);
    localparam logic [15:0] GapLast  = 16'(CS_GAP - 1);
    localparam logic [15:0] ClrLast  = 16'(CLR_CYCLES - 1);

    dac_cmd_t wr_cmd, head;
    logic     fifo_full, fifo_empty, pop;

    state_e                  state_q, state_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [5:0]              bit_cnt_q, bit_cnt_d;
    logic [DEV_BITS-1:0]     cur_dev_q, cur_dev_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [FRAME_BITS-1:0]   echo_sr_q, echo_sr_d;
    logic [31:0]             echo_data_q, echo_data_d;
    logic                    done_q, done_d;
    logic                    bad_dev_q, bad_dev_d;
    logic                    clear_pend_q, clear_pend_d;
    logic                    gap_setup_q, gap_setup_d;
    logic                    in_frame, sdo_bit;

    always_comb begin
        wr_cmd           = '0;
        wr_cmd.broadcast = s.s_broadcast;
        wr_cmd.dev       = DEV_BITS'(s.s_dev);
        wr_cmd.cmd       = s.s_cmd;
        wr_cmd.addr      = s.s_addr;
        wr_cmd.data      = CODE_BITS'(s.s_data) << (CODE_BITS - DATA_WIDTH);
    end

    ltc2600_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s.s_valid),
        .wdata (wr_cmd),
        .full  (fifo_full),
        .pop   (pop),
        .rdata (head),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign s.s_ready = !fifo_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            cur_dev_q    <= '0;
            shift_q      <= '0;
            echo_sr_q    <= '0;
            echo_data_q  <= '0;
            done_q       <= 1'b0;
            bad_dev_q    <= 1'b0;
            clear_pend_q <= 1'b0;
            gap_setup_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            cur_dev_q    <= cur_dev_d;
            shift_q      <= shift_d;
            echo_sr_q    <= echo_sr_d;
            echo_data_q  <= echo_data_d;
            done_q       <= done_d;
            bad_dev_q    <= bad_dev_d;
            clear_pend_q <= clear_pend_d;
            gap_setup_q  <= gap_setup_d;
        end
    end

    always_comb begin
        sdo_bit = 1'b0;
        for (int i = 0; i < N_DEV; i++) begin
            if (cur_dev_q == DEV_BITS'(i)) sdo_bit = sdo[i];
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 16'd1;
        bit_cnt_d    = bit_cnt_q;
        cur_dev_d    = cur_dev_q;
        shift_d      = shift_q;
        echo_sr_d    = echo_sr_q;
        echo_data_d  = echo_data_q;
        done_d       = 1'b0;
        bad_dev_d    = 1'b0;
        gap_setup_d  = gap_setup_q;
        pop          = 1'b0;
        clear_pend_d = clear_pend_q | clear_req;

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (clear_pend_q) begin
                    state_d      = StClear;
                    clear_pend_d = 1'b0;
                end else if (!fifo_empty) begin
                    if (!head.broadcast && (32'(head.dev) >= N_DEV)) begin
                        pop       = 1'b1;
                        bad_dev_d = 1'b1;
                    end else begin
                        state_d   = StSetup;
                        cur_dev_d = head.broadcast ? '0 : head.dev;
                        shift_d   = build_frame(head);
                        bit_cnt_d = '0;
                    end
                end
            end
            StClear: begin
                clear_pend_d = 1'b0;  // requests during the clear itself are dropped
                if (cnt_q == ClrLast) begin
                    state_d     = StGap;
                    cnt_d       = '0;
                    gap_setup_d = 1'b0;
                end
            end
            StSetup: begin
                if (cnt_q == DivLast) begin
                    state_d = StSckHi;
                    cnt_d   = '0;
                end
            end
            StSckHi: begin
                if (cnt_q == DivLast) begin
                    echo_sr_d = {echo_sr_q[FRAME_BITS-2:0], sdo_bit};
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    state_d   = StSckLo;
                    cnt_d     = '0;
                end
            end
            StSckLo: begin
                if (cnt_q == DivLast) begin
                    cnt_d   = '0;
                    state_d = (bit_cnt_q == 6'(FRAME_BITS)) ? StHold : StSckHi;
                end
            end
            StHold: begin
                if (cnt_q == HoldLast) begin
                    done_d      = 1'b1;
                    echo_data_d = echo_sr_q;
                    state_d     = StGap;
                    cnt_d       = '0;
                    if (head.broadcast && (32'(cur_dev_q) < N_DEV - 1)) begin
                        cur_dev_d   = cur_dev_q + DEV_BITS'(1);
                        gap_setup_d = 1'b1;
                    end else begin
                        pop         = 1'b1;
                        gap_setup_d = 1'b0;
                    end
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    cnt_d = '0;
                    if (gap_setup_q) begin
                        state_d   = StSetup;
                        shift_d   = build_frame(head);
                        bit_cnt_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign in_frame = (state_q == StSetup) || (state_q == StSckHi) ||
                      (state_q == StSckLo) || (state_q == StHold);

    always_comb begin
        csb = '1;
        for (int i = 0; i < N_DEV; i++) begin
            csb[i] = !(in_frame && (cur_dev_q == DEV_BITS'(i)));
        end
    end

    assign sck       = (state_q == StSckHi);
    assign sdi       = in_frame ? shift_q[FRAME_BITS-1] : 1'b0;
    assign clrb      = (state_q != StClear);
    assign busy      = (state_q != StIdle) || !fifo_empty;
    assign done      = done_q;
    assign bad_dev   = bad_dev_q;
    assign echo_data = echo_data_q;

endmodule

// File: tb/tb_ltc2600_multi_writer.sv
// Directed bench: a frame-level model predicts frames, clears and bad-device drops in order;
// a pin monitor rebuilds what appears on the wires and compares every cycle.
module tb_ltc2600_multi_writer;
    localparam int N_DEV      = 3;
    localparam int DEV_W      = 2;
    localparam int FIFO_DEPTH = 8;
    localparam int SCK_DIV    = 2;
    localparam int CS_HOLD    = 2;
    localparam int CS_GAP     = 4;
    localparam int CLR_CYCLES = 8;
    localparam int FRAME_LEN  = SCK_DIV * 65 + CS_HOLD;
    localparam int KFrame = 0, KBad = 1, KClear = 2;

    typedef struct {
        int          kind;
        int          dev;
        logic [31:0] word;
    } ev_t;

    logic clk, rst, clear_req;
    logic [N_DEV-1:0] sdo, csb;
    logic sck, sdi, clrb, busy, done, bad_dev;
    logic [31:0] echo_data;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;

    ltc2600_multi_writer_if #(.DATA_WIDTH(16), .DEV_W(DEV_W)) sif ();

    ltc2600_multi_writer #(
        .DATA_WIDTH (16),
        .N_DEV      (N_DEV),
        .FIFO_DEPTH (FIFO_DEPTH),
        .SCK_DIV    (SCK_DIV),
        .CS_HOLD    (CS_HOLD),
        .CS_GAP     (CS_GAP),
        .CLR_CYCLES (CLR_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s          (sif),
        .clear_req  (clear_req),
        .sdo        (sdo),
        .sck        (sck),
        .sdi        (sdi),
        .csb        (csb),
        .clrb       (clrb),
        .busy       (busy),
        .done       (done),
        .echo_data  (echo_data),
        .bad_dev    (bad_dev),
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;
    ev_t exp_q[$];
    logic [31:0] pat [N_DEV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] frame_word(input logic [3:0] cmd, input logic [3:0] addr,
                                               input logic [15:0] data);
        return 32'(cmd) * 32'h0010_0000 + 32'(addr) * 32'h0001_0000 + 32'(data);
    endfunction

    task automatic push(input logic b, input logic [DEV_W-1:0] dev, input logic [3:0] cmd,
                        input logic [3:0] addr, input logic [15:0] data);
        int n = 0;
        ev_t e;
        @(negedge clk);
        sif.s_valid = 1'b1; sif.s_broadcast = b; sif.s_dev = dev;
        sif.s_cmd = cmd; sif.s_addr = addr; sif.s_data = data;
        while (!sif.s_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", n < 1000, 1);
        @(posedge clk);
        if (b) begin
            for (int d = 0; d < N_DEV; d++) begin
                e.kind = KFrame; e.dev = d; e.word = frame_word(cmd, addr, data);
                exp_q.push_back(e);
            end
        end else if (32'(dev) >= N_DEV) begin
            e.kind = KBad; e.dev = int'(dev); e.word = '0;
            exp_q.push_back(e);
        end else begin
            e.kind = KFrame; e.dev = int'(dev); e.word = frame_word(cmd, addr, data);
            exp_q.push_back(e);
        end
        #1 sif.s_valid = 1'b0;
    endtask

    task automatic expect_clear();
        ev_t e;
        e.kind = KClear; e.dev = 0; e.word = '0;
        exp_q.push_back(e);
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1 clear_req = 1'b1;
        @(posedge clk); #1 clear_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || exp_q.size() != 0 || !clrb) && n < budget);
        check("idle_timeout", n < budget, 1);
    endtask

    // Pin monitor
    logic prev_sck, prev_sdi;
    bit in_frame;
    int fdev, flen, nrises, gap, clr_len;
    logic [31:0] fword, last_word;
    int last_len, last_dev, frames_seen = 0, clears_seen = 0, bad_seen = 0;

    always @(negedge clk) begin
        int nlow, idx;
        bit fend;
        ev_t e;
        if (rst) begin
            in_frame = 0; clr_len = 0; gap = 1000; prev_sck = 0; prev_sdi = 0;
        end else begin
            nlow = 0; idx = 0; fend = 0;
            for (int i = 0; i < N_DEV; i++) if (!csb[i]) begin nlow++; idx = i; end
            check("csb_onehot", nlow <= 1, 1);
            if (sck) check("sck_needs_csb", nlow, 1);
            if (sck) check("sdi_stable", sdi, prev_sdi);
            if (!clrb) check("clr_outside_frame", nlow, 0);
            if (nlow == 1) begin
                if (!in_frame) begin
                    check("cs_gap", gap >= CS_GAP, 1);
                    in_frame = 1; fdev = idx; flen = 0; fword = '0; nrises = 0;
                end
                check("csb_steady", idx, fdev);
                flen++;
                if (sck && !prev_sck) begin
                    fword = {fword[30:0], sdi};
                    if (nrises < 32) sdo[fdev] = pat[fdev][31-nrises];
                    nrises++;
                end
                gap = 0;
            end else begin
                gap++;
                if (in_frame) begin
                    fend = 1; in_frame = 0;
                    if (exp_q.size() == 0) check("unexpected_frame", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("frame_kind", e.kind, KFrame);
                        check("frame_dev", fdev, e.dev);
                        check("frame_word", fword, e.word);
                    end
                    check("frame_len", flen, FRAME_LEN);
                    check("sck_rises", nrises, 32);
                    check("echo_data", echo_data, pat[fdev]);
                    last_word = fword; last_dev = fdev; last_len = flen;
                    frames_seen++;
                end
            end
            check("done_pulse", done, fend);
            if (bad_dev) begin
                bad_seen++;
                if (exp_q.size() == 0) check("unexpected_bad_dev", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("bad_dev_kind", e.kind, KBad);
                end
            end
            if (!clrb) clr_len++;
            else if (clr_len > 0) begin
                check("clr_len", clr_len, CLR_CYCLES);
                if (exp_q.size() == 0) check("unexpected_clear", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("clear_kind", e.kind, KClear);
                end
                clr_len = 0;
                clears_seen++;
            end
            prev_sck = sck; prev_sdi = sdi;
        end
    end

    initial begin
        #600000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int f0, c0, b0, n;
        pat[0] = 32'hC3A5_0F96; pat[1] = 32'h1234_5678; pat[2] = 32'h8E1D_B247;
        rst = 1'b1; clear_req = 1'b0; sdo = '0;
        sif.s_valid = 1'b0; sif.s_broadcast = 1'b0; sif.s_dev = '0;
        sif.s_cmd = '0; sif.s_addr = '0; sif.s_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_csb", csb, 3'b111);
        check("rst_sck", sck, 0);
        check("rst_sdi", sdi, 0);
        check("rst_clrb", clrb, 1);
        check("rst_echo", echo_data, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ready", sif.s_ready, 1);
        check("rst_busy", busy, 0);

        // Single write to chip 0
        push(0, 0, 4'h3, 4'h5, 16'hABCD);
        wait_idle(600);
        check("t1_word", last_word, 32'h0035_ABCD);
        check("t1_len", last_len, 132);
        check("t1_dev", last_dev, 0);

        // Broadcast: one entry, a frame per chip, single pop at the end
        f0 = frames_seen;
        push(1, 0, 4'h2, 4'hF, 16'h8000);
        n = 0;
        while (frames_seen == f0 && n < 500) begin @(negedge clk); n++; end
        check("t2_level_mid", fifo_level, 1);
        wait_idle(1000);
        check("t2_frames", frames_seen - f0, 3);
        check("t2_word", last_word, 32'h002F_8000);
        check("t2_last_dev", last_dev, 2);
        check("t2_level_end", fifo_level, 0);

        // Fill the FIFO, then a ninth entry must wait for the first pop
        f0 = frames_seen;
        for (int i = 0; i < 8; i++) push(0, DEV_W'(i % 3), 4'h3, 4'(i), 16'(i * 16'h1111));
        @(negedge clk);
        check("t3_level_full", fifo_level, 8);
        check("t3_ready_full", sif.s_ready, 0);
        push(0, 1, 4'h0, 4'h9, 16'h9999);
        wait_idle(3000);
        check("t3_frames", frames_seen - f0, 9);
        check("t3_last_word", last_word, 32'h0009_9999);

        // Clear during a frame: merged requests, served after the frame, before the next entry
        c0 = clears_seen;
        push(0, 1, 4'h3, 4'h7, 16'h0F0F);
        n = 0;
        while (!(in_frame && nrises >= 3) && n < 300) begin @(negedge clk); n++; end
        pulse_clear();
        pulse_clear();
        expect_clear();
        push(0, 2, 4'h3, 4'h8, 16'hF0F0);
        n = 0;
        while (clrb && n < 400) begin @(negedge clk); n++; end
        check("t4_clear_seen", clrb, 0);
        pulse_clear();
        wait_idle(1000);
        check("t4_clears", clears_seen - c0, 1);
        check("t4_last_word", last_word, 32'h0038_F0F0);

        // Reset mid-frame, with a clear pending and a second entry queued
        c0 = clears_seen; f0 = frames_seen;
        push(0, 0, 4'h3, 4'h1, 16'h1111);
        push(0, 2, 4'h3, 4'h2, 16'h2222);
        n = 0;
        while (!(in_frame && nrises >= 5) && n < 300) begin @(negedge clk); n++; end
        pulse_clear();
        n = 0;
        while (!(in_frame && nrises >= 10) && n < 300) begin @(negedge clk); n++; end
        check("t5_reached_bit10", nrises >= 10, 1);
        @(posedge clk); #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        check("t5_csb", csb, 3'b111);
        check("t5_sck", sck, 0);
        check("t5_level", fifo_level, 0);
        check("t5_done", done, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (60) @(negedge clk);
        check("t5_no_frames", frames_seen - f0, 0);
        check("t5_no_clear", clears_seen - c0, 0);
        check("t5_busy", busy, 0);

        // Out-of-range chip index, then an echo capture from chip 1
        b0 = bad_seen; f0 = frames_seen;
        push(0, 3, 4'h3, 4'h1, 16'h1234);
        wait_idle(100);
        check("t6_bad", bad_seen - b0, 1);
        check("t6_no_frame", frames_seen - f0, 0);
        push(0, 1, 4'h0, 4'h2, 16'h5555);
        wait_idle(600);
        check("t6_echo", echo_data, 32'h1234_5678);
        check("t6_word", last_word, 32'h0002_5555);

        check("model_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
